// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default bit timing.
// Used by both the UART transmitter and receiver.
package uart_pkg;

  localparam int DIV_WID_DEF = 7;
  localparam int DIV_CNT_DEF = 86;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, resets to 1.
// Suitable for any idle-high asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Emits a one-cycle valid strobe per good byte, or a framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_WID = DIV_WID_DEF,
  parameter int DIV_CNT = DIV_CNT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_mosi,
  output logic [7:0] o_rxdata,
  output logic       o_rxvalid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [DIV_WID-1:0] RELOAD = DIV_WID'(DIV_CNT);
  localparam logic [DIV_WID-1:0] HALF   = DIV_WID'(DIV_CNT / 2);

  uart_state_e        state, state_n;
  logic [DIV_WID-1:0] div, div_n;
  logic [3:0]         bit_cnt, cnt_n;
  logic [7:0]         shreg, sh_n;
  logic [7:0]         data_n;
  logic               valid_n, ferr_n;
  logic               rx_s;
  logic               samp;

  sync_2ff u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_uart_mosi),
    .q   (rx_s)
  );

  assign samp   = (div == '0);
  assign o_busy = (state != IDLE);

  // state and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_rxdata    <= '0;
      o_rxvalid   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      bit_cnt     <= cnt_n;
      shreg       <= sh_n;
      o_rxdata    <= data_n;
      o_rxvalid   <= valid_n;
      o_frame_err <= ferr_n;
    end
  end

  // next-state, bit timing and shift logic
  always_comb begin
    state_n = state;
    div_n   = div;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    data_n  = o_rxdata;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        div_n = '0;
        if (!rx_s) begin
          state_n = START;
          div_n   = HALF;
        end
      end
      START: begin
        div_n = div - 1'b1;
        if (samp) begin
          if (!rx_s) begin
            state_n = DATA;
            div_n   = RELOAD;
            cnt_n   = 4'd0;
          end else begin
            state_n = IDLE;
            div_n   = '0;
          end
        end
      end
      DATA: begin
        div_n = div - 1'b1;
        if (samp) begin
          sh_n  = {rx_s, shreg[7:1]};
          cnt_n = bit_cnt + 4'd1;
          div_n = RELOAD;
          if (bit_cnt == 4'd7) state_n = STOP;
        end
      end
      STOP: begin
        div_n = div - 1'b1;
        if (samp) begin
          div_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end
        end
      end
      BRK: begin
        div_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level model.
// Expected bytes and strobe times come from the frame format and bit timing.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_uart_mosi;
  logic [7:0] o_rxdata;
  logic       o_rxvalid;
  logic       o_frame_err;
  logic       o_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         t;
    logic [7:0] d;
  } ev_t;

  ev_t        vq[$];
  int         eq[$];
  logic [7:0] exp_q[$];

  uart_rx dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_mosi (i_uart_mosi),
    .o_rxdata    (o_rxdata),
    .o_rxvalid   (o_rxvalid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_rxvalid === 1'b1) vq.push_back('{cyc, o_rxdata});
    if (o_frame_err === 1'b1) eq.push_back(cyc);
    if (o_rxvalid === 1'b1 || o_frame_err === 1'b1)
      chk("excl", {31'b0, o_rxvalid & o_frame_err}, 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic to_neg(input int x);
    @(negedge i_clk);
    while (cyc < x) @(negedge i_clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    i_uart_mosi = b;
    step(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic stop, output int fall);
    fall = cyc;
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    send_bit(stop, p);
    if (stop) exp_q.push_back(d);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_cnt"}, vq.size(), exp_q.size());
    while (vq.size() > 0 && exp_q.size() > 0) begin
      ev_t e;
      e = vq.pop_front();
      chk({tag, "_data"}, {24'b0, e.d}, {24'b0, exp_q.pop_front()});
    end
    vq.delete();
    exp_q.delete();
  endtask

  initial begin
    int         f;
    int         f2;
    logic [7:0] r;
    int         per[3];
    per[0] = 84;
    per[1] = 90;
    per[2] = 87;

    i_uart_mosi = 1'b1;
    i_rst = 1'b1;
    step(3);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_data", {24'b0, o_rxdata}, 0);
    chk("rst_valid", {31'b0, o_rxvalid}, 0);
    chk("rst_ferr", {31'b0, o_frame_err}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    step(3);

    send_frame(8'h55, 87, 1'b1, f);
    chk("t55", vq.size() > 0 ? vq[0].t : -1, f + 830);
    step(5);
    chk("busy55", {31'b0, o_busy}, 0);
    check_rx("b55");

    f = cyc;
    i_uart_mosi = 1'b0;
    step(20);
    i_uart_mosi = 1'b1;
    to_neg(f + 46);
    chk("glitch_busy_hi", {31'b0, o_busy}, 1);
    to_neg(f + 47);
    chk("glitch_busy_lo", {31'b0, o_busy}, 0);
    step(1);
    chk("glitch_nv", vq.size(), 0);
    chk("glitch_nf", eq.size(), 0);

    send_frame(8'hA5, 87, 1'b0, f);
    send_bit(1'b0, 261);
    i_uart_mosi = 1'b1;
    step(10);
    chk("ferr_cnt", eq.size(), 1);
    chk("ferr_t", eq.size() > 0 ? eq[0] : -1, f + 830);
    chk("ferr_nv", vq.size(), 0);
    chk("ferr_hold", {24'b0, o_rxdata}, 8'h55);
    chk("ferr_busy", {31'b0, o_busy}, 0);
    eq.delete();
    send_frame(8'h3C, 87, 1'b1, f);
    step(10);
    check_rx("b3c");

    send_frame(8'h00, 87, 1'b1, f);
    send_frame(8'hFF, 87, 1'b1, f2);
    step(10);
    chk("b2b_gap", vq.size() > 1 ? vq[1].t - vq[0].t : -1, 870);
    chk("b2b_t", vq.size() > 1 ? vq[1].t : -1, f2 + 830);
    check_rx("b2b");

    r = 8'($urandom);
    send_bit(1'b0, 87);
    for (int i = 0; i < 4; i++) send_bit(r[i], 87);
    i_uart_mosi = r[4];
    step(40);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    i_uart_mosi = 1'b1;
    step(1000);
    chk("abort_nv", vq.size(), 0);
    chk("abort_nf", eq.size(), 0);
    chk("abort_busy", {31'b0, o_busy}, 0);
    chk("abort_data", {24'b0, o_rxdata}, 0);
    send_frame(8'h81, 87, 1'b1, f);
    step(10);
    check_rx("b81");

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 10; n++) begin
        r = 8'($urandom);
        send_frame(r, per[k], 1'b1, f);
        step(20);
      end
      step(20);
      check_rx($sformatf("rand%0d", per[k]));
      chk("rand_nf", eq.size(), 0);
      eq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
